// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: redirect input from the next-PC stage, the
// instruction-memory request/response channel and the decode-side output.
interface instr_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // The fetch unit itself.
    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_data, inst_pc
    );

    // The surroundings: next-PC stage, instruction memory and decode.
    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Issues sequential word fetches, buffers in-order
// responses in a 2-entry {pc,data} FIFO for decode, and on a redirect
// restarts at the new address while discarding responses still in flight.
// Request credit (outstanding + buffered < 2) guarantees the FIFO never
// overflows, so memory responses need no backpressure.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    // Control state
    logic [31:0] fetch_ptr_q, fetch_ptr_d;
    logic [31:0] rsp_pc_q,    rsp_pc_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_cnt_q,  drop_cnt_d;
    logic [1:0]  fifo_cnt_q,  fifo_cnt_d;
    logic        rd_ptr_q,    rd_ptr_d;

    // FIFO storage (contents only meaningful while counted as valid)
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_data_q [2];

    // Per-cycle events
    logic [2:0]  credit_used;
    logic        req_valid;
    logic        req_acc;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        inst_pop;
    logic        wr_idx;

    // Handshake decode: credit check, accept, keep/drop and pop decisions.
    always_comb begin
        credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
        // Gated by reset so the request is low while reset is held, even
        // though the cleared counters would otherwise grant credit.
        req_valid   = reset && (credit_used < 3'd2) && !bus.redirect_valid;
        req_acc     = req_valid && bus.imem_req_ready;
        // A redirect cycle ignores both the response and the pop.
        rsp_keep    = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q == 2'd0);
        rsp_drop    = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q != 2'd0);
        inst_pop    = (fifo_cnt_q != 2'd0) && bus.inst_ready && !bus.redirect_valid;
        // Tail slot; a keep into a full FIFO cannot happen under the credit rule.
        wr_idx      = rd_ptr_q ^ fifo_cnt_q[0];
    end

    // Next-state for pointers and counters.
    always_comb begin
        fetch_ptr_d   = fetch_ptr_q;
        rsp_pc_d      = rsp_pc_q;
        // Every response retires an outstanding request, kept or dropped,
        // including one that arrives during a redirect.
        outstanding_d = outstanding_q + {1'b0, req_acc} - {1'b0, bus.imem_rsp_valid};
        drop_cnt_d    = drop_cnt_q;
        fifo_cnt_d    = fifo_cnt_q;
        rd_ptr_d      = rd_ptr_q;

        if (bus.redirect_valid) begin
            fetch_ptr_d = bus.redirect_pc;
            rsp_pc_d    = bus.redirect_pc;
            // Everything still in flight after this edge predates the redirect.
            drop_cnt_d  = outstanding_q - {1'b0, bus.imem_rsp_valid};
            fifo_cnt_d  = 2'd0;
            rd_ptr_d    = 1'b0;
        end else begin
            if (req_acc) begin
                fetch_ptr_d = fetch_ptr_q + 32'd4;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, rsp_keep} - {1'b0, inst_pop};
            rd_ptr_d   = rd_ptr_q ^ inst_pop;
        end
    end

    // Control registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_ptr_q   <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            fifo_cnt_q    <= 2'd0;
            rd_ptr_q      <= 1'b0;
        end else begin
            fetch_ptr_q   <= fetch_ptr_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO payload write; validity is tracked by fifo_cnt_q alone.
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            fifo_pc_q[wr_idx]   <= rsp_pc_q;
            fifo_data_q[wr_idx] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_ptr_q;
    // No bypass: only registered FIFO contents reach decode.
    assign bus.inst_valid     = (fifo_cnt_q != 2'd0);
    assign bus.inst_data      = fifo_data_q[rd_ptr_q];
    assign bus.inst_pc        = fifo_pc_q[rd_ptr_q];

endmodule
